// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: AXI4-Lite read master that fetches one instruction per PC and hands it to the IDU.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_axi_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            next_pc_valid,
  input  logic [XLEN-1:0] next_pc,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pc_pending_q, pc_pending_d;
  logic              capture;
  logic [XLEN-1:0]   next_pc_aligned;
  logic              unused_next_pc_lsbs;

  assign next_pc_aligned     = {next_pc[XLEN-1:2], 2'b00};
  assign unused_next_pc_lsbs = ^next_pc[1:0];

  // IDLE doubles as the wait-for-next-PC state; pc_pending selects which.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_pending_d = pc_pending_q;
    capture      = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    inst_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!pc_pending_q) begin
          state_d = REQ;
        end else if (next_pc_valid) begin
          pc_d         = next_pc_aligned;
          pc_pending_d = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        arvalid = 1'b1;
        if (arready) state_d = WAIT_R;
      end
      WAIT_R: begin
        rready = 1'b1;
        if (rvalid) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          if (next_pc_valid) begin
            pc_d    = next_pc_aligned;
            state_d = REQ;
          end else begin
            pc_pending_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC[XLEN-1:0];
      pc_pending_q <= 1'b0;
      inst         <= '0;
      inst_pc      <= '0;
      inst_fault   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_pending_q <= pc_pending_d;
      if (capture) begin
        inst       <= rdata;
        inst_pc    <= pc_q;
        inst_fault <= (rresp != 2'b00);
      end
    end
  end

  assign araddr = pc_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == REQ || state_q == WAIT_R) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && next_pc_valid &&
        (state_q == REQ || state_q == WAIT_R || (state_q == HOLD && !inst_ready)))
      $error("ifu_axi_fetch: next_pc_valid ignored in state %0d", state_q);
  end
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Randomized bench for ifu_axi_fetch: plays AXI slave, IDU and WBU against a transaction-level model.
// Directed fetches come first, then a mid-read reset with a stale rvalid, then random traffic.
module tb_ifu_axi_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, rdata, inst, inst_pc, next_pc, perf_fetch_cnt, perf_stall_cnt;
  logic        arvalid, arready, rvalid, rready, inst_fault, inst_valid, inst_ready, next_pc_valid;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  ifu_axi_fetch #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus-level phase of the current fetch as seen from outside the IFU.
  typedef enum {P_BOOT, P_ADDR, P_DATA, P_DELIVER, P_NEEDPC} phase_t;

  phase_t      ph;
  logic [31:0] m_pc, m_inst, m_inst_pc;
  logic        m_fault;
  logic [31:0] m_fetches, m_stalls;
  int unsigned wcnt;

  // Per-fetch behaviour of the environment.
  int unsigned k_ar, k_r, k_idu, k_pcw;
  bit          k_pcnow;
  logic [31:0] k_data, k_npc;
  logic [1:0]  k_resp;
  int unsigned fidx;

  task automatic pick_knobs();
    k_ar = 0; k_r = 0; k_idu = 0; k_pcw = 0; k_pcnow = 1'b1;
    k_data = $urandom; k_resp = 2'b00; k_npc = m_pc + 32'd4;
    case (fidx)
      0: k_data = 32'h0000_0413;
      1: begin k_ar = 3; k_r = 5; end
      2: k_idu = 6;
      3: begin k_data = 32'hDEAD_BEEF; k_resp = 2'b10; end
      4: begin k_pcnow = 1'b0; k_pcw = 3; end
      5: k_npc = 32'h8000_0102;
      6: k_r = 6;
      default: begin
        k_ar    = $urandom_range(0, 3);
        k_r     = $urandom_range(0, 4);
        k_idu   = $urandom_range(0, 3);
        k_pcnow = 1'($urandom_range(0, 1));
        k_pcw   = $urandom_range(0, 4);
        k_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        k_npc   = $urandom;
      end
    endcase
    fidx++;
  endtask

  task automatic compare_all();
    chk("arvalid",    32'(arvalid),    32'(ph == P_ADDR));
    chk("rready",     32'(rready),     32'(ph == P_DATA));
    chk("inst_valid", 32'(inst_valid), 32'(ph == P_DELIVER));
    chk("araddr",     araddr,          m_pc);
    chk("inst",       inst,            m_inst);
    chk("inst_pc",    inst_pc,         m_inst_pc);
    chk("inst_fault", 32'(inst_fault), 32'(m_fault));
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, m_fetches);
    chk("perf_stall", perf_stall_cnt, m_stalls);
`else
    chk("perf_fetch", perf_fetch_cnt, 32'h0);
    chk("perf_stall", perf_stall_cnt, 32'h0);
`endif
  endtask

  // Advance the model across one rising edge using the inputs just driven.
  task automatic step();
    phase_t nph;
    if (rst) begin
      ph = P_BOOT; m_pc = RST_PC; m_inst = '0; m_inst_pc = '0; m_fault = 1'b0;
      m_fetches = '0; m_stalls = '0; wcnt = 0;
      return;
    end
    nph = ph;
    case (ph)
      P_BOOT:    nph = P_ADDR;
      P_ADDR:    if (arready) nph = P_DATA;
      P_DATA:    if (rvalid) begin
                   m_inst = rdata; m_inst_pc = m_pc; m_fault = (rresp != 2'b00);
                   m_fetches++;
                   nph = P_DELIVER;
                 end
      P_DELIVER: if (inst_ready) begin
                   if (next_pc_valid) begin m_pc = next_pc & 32'hFFFF_FFFC; nph = P_ADDR; end
                   else nph = P_NEEDPC;
                 end
      P_NEEDPC:  if (next_pc_valid) begin m_pc = next_pc & 32'hFFFF_FFFC; nph = P_ADDR; end
      default:   nph = P_BOOT;
    endcase
    if (ph == P_ADDR || ph == P_DATA) m_stalls++;
    wcnt = (nph == ph) ? wcnt + 1 : 0;
    if (nph == P_ADDR && ph != P_ADDR) pick_knobs();
    ph = nph;
  endtask

  initial begin
    bit          rst_done = 1'b0;
    bit          rst_trig;
    int unsigned stale = 0;

    rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    inst_ready = 1'b0; next_pc_valid = 1'b0; next_pc = '0;
    fidx = 0; ph = P_BOOT; m_pc = RST_PC; wcnt = 0;

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (cyc > 0) compare_all();

      rst_trig = 1'b0;
      if (!rst_done && fidx == 7 && ph == P_DATA && wcnt == 1) begin
        rst_trig = 1'b1; rst_done = 1'b1; stale = 2;
      end
      rst = (cyc < 3) || rst_trig;

      arready = (ph == P_ADDR) ? (wcnt >= k_ar) : 1'($urandom_range(0, 1));
      if (ph == P_DATA) rvalid = (wcnt >= k_r);
      else              rvalid = (stale > 0 && !rst) ? 1'b1 : ($urandom_range(0, 3) == 0);
      if (!rst && stale > 0) stale--;
      rdata = (ph == P_DATA && rvalid) ? k_data : $urandom;
      rresp = (ph == P_DATA && rvalid) ? k_resp : 2'($urandom_range(0, 3));
      inst_ready = (ph == P_DELIVER) ? (wcnt >= k_idu) : 1'($urandom_range(0, 1));
      if (ph == P_DELIVER)     next_pc_valid = inst_ready && k_pcnow;
      else if (ph == P_NEEDPC) next_pc_valid = (wcnt >= k_pcw);
      else                     next_pc_valid = 1'b0;
      next_pc = next_pc_valid ? k_npc : $urandom;

      step();
    end

    @(negedge clk);
    compare_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
